// File: rtl/subckt_sig_pkg.sv
// rtl/subckt_sig_pkg.sv - shared types and default constants for the signature monitor
package subckt_sig_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subckt_sisr.sv
// rtl/subckt_sisr.sv - serial-input signature register with load and enable
module subckt_sisr
  import subckt_sig_pkg::*;
#(
  parameter int             SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             serial_in,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic             fb;
  logic [SIG_W-1:0] shifted;

  // Next-signature selection; exported so the FSM can judge the final value on the same edge
  always_comb begin
    fb       = sig[SIG_W-1] ^ serial_in;
    shifted  = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    sig_next = sig;
    if (load) begin
      sig_next = SEED;
    end else if (enable) begin
      sig_next = shifted;
    end
  end

  // Signature register; reset clears to zero, not to SEED
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/subckt_sig_monitor.sv
// rtl/subckt_sig_monitor.sv - capture-window signature compactor with golden compare
module subckt_sig_monitor
  import subckt_sig_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = SEED_DEF
) (
  input  logic             I1294,
  input  logic             I1301,
  input  logic             start,
  input  logic [7:0]       win_len,
  input  logic [SIG_W-1:0] golden,
  input  logic             I3120,
  input  logic             obs_valid,
  output logic [SIG_W-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [7:0]       count;
  logic [7:0]       win_len_q;
  logic [SIG_W-1:0] golden_q;
  logic [SIG_W-1:0] sig_next;
  logic             accept;
  logic             shift_en;
  logic             last_bit;

  assign accept   = (state == ST_IDLE) && start;
  assign shift_en = (state == ST_RUN) && obs_valid;
  assign last_bit = shift_en && ((count + 8'd1) == win_len_q);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  subckt_sisr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_sisr (
    .clk       (I1294),
    .rst       (I1301),
    .load      (accept),
    .enable    (shift_en),
    .serial_in (I3120),
    .sig       (sig),
    .sig_next  (sig_next)
  );

  // Window control: accept start, count valid bits, judge the final signature
  always_ff @(posedge I1294) begin
    if (I1301) begin
      state     <= ST_IDLE;
      count     <= 8'd0;
      win_len_q <= 8'd0;
      golden_q  <= '0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count     <= 8'd0;
            win_len_q <= win_len;
            golden_q  <= golden;
            if (win_len == 8'd0) begin
              // empty window: the signature stays at SEED, so judge it now
              state    <= ST_DONE;
              mismatch <= (SEED != golden);
            end else begin
              state    <= ST_RUN;
              mismatch <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (shift_en) begin
            count <= count + 8'd1;
            if (last_bit) begin
              state    <= ST_DONE;
              mismatch <= (sig_next != golden_q);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/subckt_sig_monitor.md
SUBCKT_SIG_MONITOR -- requirements
Module: subckt_sig_monitor

Interface
REQ-001 Parameter SIG_W, default 16: signature width in bits.
REQ-002 Parameter POLY, default 16'h1021: feedback polynomial XOR mask (SIG_W bits).
REQ-003 Parameter SEED, default 16'h0000: signature value loaded on start.
REQ-004 I1294  input  1  clock; all state updates on the rising edge.
REQ-005 I1301  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  begin a capture window; honoured only in IDLE.
REQ-007 win_len  input  8  number of valid bits to compact; sampled on an accepted start.
REQ-008 golden  input  SIG_W  expected signature; sampled on an accepted start.
REQ-009 I3120  input  1  observed output bit of the upstream subcircuit.
REQ-010 obs_valid  input  1  qualifies I3120 for the current cycle.
REQ-011 sig  output  SIG_W  current signature register.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse marking the end of the window.
REQ-014 mismatch  output  1  final signature differs from golden; held until the next accepted start.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL load sig=SEED, count=0 and capture win_len and golden; it SHALL clear mismatch, then go to RUN, or to DONE if win_len=0.
REQ-017 In RUN, each cycle with obs_valid=1 SHALL update sig to (sig<<1) XOR (fb ? POLY : 0), where fb = sig[SIG_W-1] XOR I3120, and SHALL increment count.
REQ-018 In RUN, cycles with obs_valid=0 SHALL leave sig and count unchanged, with no timeout.
REQ-019 On the edge that accepts the win_len-th valid bit, the block SHALL enter DONE and register mismatch = (next sig != captured golden).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; sig SHALL hold its final value until the next start.
REQ-021 With win_len=0, DONE SHALL follow start by one cycle, with sig=SEED and mismatch = (SEED != golden).
REQ-022 start SHALL be ignored in RUN and DONE; a start asserted in the DONE cycle is dropped.
REQ-023 Changes to win_len and golden after an accepted start SHALL have no effect on the current window.
REQ-024 count SHALL be 8 bits wide and SHALL not wrap, because the window terminates at win_len <= 255.
REQ-025 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be registered-state decodes.

Reset
REQ-026 I1301=1 at a rising edge SHALL force state=IDLE, sig=0, count=0, mismatch=0, busy=0 and done=0, overriding start and obs_valid.
REQ-027 Reset asserted mid-window SHALL abandon the window; after reset, no done pulse occurs until a new start.

Structure
REQ-028 Package subckt_sig_pkg SHALL hold the state enum and the default POLY, SEED and SIG_W constants.
REQ-029 The shift/feedback datapath SHALL be one sub-module, subckt_sisr, with load, enable and serial-in ports; the FSM and counter stay in subckt_sig_monitor.

Verification
REQ-030 The bench SHALL cover: start, win_len=1, golden=16'h1021, I3120=1 valid -> sig=16'h1021, done pulse, mismatch=0.
REQ-031 The bench SHALL cover: win_len=2, bits 1,1 with an obs_valid=0 gap between them -> sig=16'h3063, done two cycles after the second bit's edge is not allowed, done the cycle after it, busy low during the gap never.
REQ-032 The bench SHALL cover: win_len=2, golden=16'h3063, bits 1,0 -> sig=16'h2042, mismatch=1 held through IDLE until the next start.
REQ-033 The bench SHALL cover: win_len=0, golden=16'h0000 -> done one cycle after start, sig=16'h0000, mismatch=0.
REQ-034 The bench SHALL cover: start repeated during RUN with golden changed -> ignored; the result matches the originally sampled golden.
REQ-035 The bench SHALL cover: I1301=1 after 3 of 5 bits -> IDLE, sig=0, no done pulse; a fresh window then completes normally.
